// File: rtl/thermo_bin_pipe_if.sv
// thermo_bin_pipe_if: valid/ready handshake bundle for the thermometer-to-binary pipeline
// Ports: in_valid/in_ready/in_therm (sample side), out_valid/out_ready/out_bin/out_bubble (result side)
// master drives samples and accepts results; slave is the pipeline's view
interface thermo_bin_pipe_if #(
    parameter int WIDTH = 15,
    parameter int BIN_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_therm;
    logic             out_valid;
    logic             out_ready;
    logic [BIN_W-1:0] out_bin;
    logic             out_bubble;
    modport master (output in_valid, in_therm, out_ready, input in_ready, out_valid, out_bin, out_bubble);
    modport slave  (input in_valid, in_therm, out_ready, output in_ready, out_valid, out_bin, out_bubble);
endinterface

// File: rtl/thermo_bin_pipe.sv
// thermo_bin_pipe: two-stage thermometer-code to binary converter with bubble detection and error count
// Ports: clk, rst (async, active-high), bus (thermo_bin_pipe_if.slave handshake),
//        clr_err (sync clear of err_count), err_count (saturating count of bubbled results delivered)
module thermo_bin_pipe #(
    parameter int WIDTH = 15,
    parameter int BIN_W = 4,
    parameter int ERR_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    thermo_bin_pipe_if.slave     bus,
    input  logic                 clr_err,
    output logic [ERR_W-1:0]     err_count
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_therm;
    logic             s1_bubble;
    logic             s1_load;
    logic             s2_load;
    logic             in_bubble;
    logic [WIDTH:0]   ext;
    logic [BIN_W-1:0] ones;

    assign s2_load     = !bus.out_valid || bus.out_ready;
    assign s1_load     = !s1_valid || s2_load;
    assign bus.in_ready = s1_load;

    // A legal LSB-anchored code plus one is a power of two, so ANDing leaves nothing;
    // the extra top bit keeps all-ones from overflowing into a false hit.
    assign ext       = {1'b0, bus.in_therm};
    assign in_bubble = |(ext & (ext + (WIDTH+1)'(1)));

    always_comb begin
        ones = '0;
        for (int i = 0; i < WIDTH; i++) ones = ones + BIN_W'(s1_therm[i]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_therm  <= '0;
            s1_bubble <= 1'b0;
        end else if (s1_load) begin
            s1_valid  <= bus.in_valid;
            s1_therm  <= bus.in_therm;
            s1_bubble <= in_bubble;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_bin    <= '0;
            bus.out_bubble <= 1'b0;
        end else if (s2_load) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.out_bin    <= ones;
                bus.out_bubble <= s1_bubble;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_count <= '0;
        else if (clr_err)
            err_count <= '0;
        else if (bus.out_valid && bus.out_ready && bus.out_bubble && err_count != '1)
            err_count <= err_count + ERR_W'(1);
    end
endmodule

// File: tb/tb_thermo_bin_pipe.sv
// tb_thermo_bin_pipe: scoreboard bench for thermo_bin_pipe
module tb_thermo_bin_pipe;
    localparam int WIDTH = 15;
    localparam int BIN_W = 4;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             clr_err = 1'b0;
    logic [ERR_W-1:0] err_count;

    thermo_bin_pipe_if #(.WIDTH(WIDTH), .BIN_W(BIN_W)) bus ();

    thermo_bin_pipe #(.WIDTH(WIDTH), .BIN_W(BIN_W), .ERR_W(ERR_W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .clr_err(clr_err),
        .err_count(err_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int exp_err = 0;
    logic [BIN_W:0] q[$];

    // legal iff the code equals a solid run of ones as long as its popcount
    function automatic logic [BIN_W:0] model(input logic [WIDTH-1:0] t);
        int n = 0;
        logic bub;
        for (int i = 0; i < WIDTH; i++) n += int'(t[i]);
        bub = (t != WIDTH'((1 << n) - 1));
        return {BIN_W'(n), bub};
    endfunction

    task automatic monitor();
        logic [BIN_W:0] e;
        logic xfer_bub;
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                q.delete();
                exp_err = 0;
            end else begin
                xfer_bub = 1'b0;
                if (bus.in_valid && bus.in_ready) q.push_back(model(bus.in_therm));
                checks++;
                if (err_count !== ERR_W'(exp_err)) $display("FAIL err_track got %0d want %0d", err_count, exp_err);
                else passes++;
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (q.size() == 0) $display("FAIL sb_unexpected got bin=%0d bub=%0b want none", bus.out_bin, bus.out_bubble);
                    else begin
                        e = q.pop_front();
                        xfer_bub = e[0];
                        if ({bus.out_bin, bus.out_bubble} !== e)
                            $display("FAIL sb_result got bin=%0d bub=%0b want bin=%0d bub=%0b", bus.out_bin, bus.out_bubble, e[BIN_W:1], e[0]);
                        else passes++;
                    end
                end
                exp_err = clr_err ? 0 : (xfer_bub && exp_err < 255) ? exp_err + 1 : exp_err;
            end
        end
    endtask

    task automatic send(input logic [WIDTH-1:0] t);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_therm = t;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            checks++;
            $display("FAIL send_timeout got in_ready=0 want 1");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        checks++;
        if (q.size() != 0) $display("FAIL drain got %0d pending want 0", q.size());
        else passes++;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL rst_in_ready got %b want 1", bus.in_ready); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", bus.out_valid); else passes++;
        checks++; if (bus.out_bin !== '0) $display("FAIL rst_out_bin got %0d want 0", bus.out_bin); else passes++;
        checks++; if (bus.out_bubble !== 1'b0) $display("FAIL rst_out_bubble got %b want 0", bus.out_bubble); else passes++;
        checks++; if (err_count !== '0) $display("FAIL rst_err got %0d want 0", err_count); else passes++;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_rst_in_ready got %b want 1", bus.in_ready); else passes++;
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_therm = 15'b000000000000111;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL first_accept got in_ready=%b want 1", bus.in_ready); else passes++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL lat_early got out_valid=%b want 0", bus.out_valid); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1) $display("FAIL lat_valid got %b want 1", bus.out_valid); else passes++;
        checks++; if (bus.out_bin !== 4'd3) $display("FAIL basic_bin got %0d want 3", bus.out_bin); else passes++;
        checks++; if (bus.out_bubble !== 1'b0) $display("FAIL basic_bub got %b want 0", bus.out_bubble); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL basic_done got out_valid=%b want 0", bus.out_valid); else passes++;
        checks++; if (err_count !== 8'd0) $display("FAIL basic_err got %0d want 0", err_count); else passes++;
    endtask

    task automatic test_bubble();
        send(15'b000000000001101);
        @(posedge clk);
        #1;
        checks++; if (bus.out_bin !== 4'd3) $display("FAIL bub_bin got %0d want 3", bus.out_bin); else passes++;
        checks++; if (bus.out_bubble !== 1'b1) $display("FAIL bub_flag got %b want 1", bus.out_bubble); else passes++;
        checks++; if (err_count !== 8'd0) $display("FAIL bub_err_pre got %0d want 0", err_count); else passes++;
        @(posedge clk);
        #1;
        checks++; if (err_count !== 8'd1) $display("FAIL bub_err_post got %0d want 1", err_count); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [BIN_W-1:0] want [3] = '{4'd0, 4'd15, 4'd6};
        send(15'h0000);
        send(15'h7FFF);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== want[0]) $display("FAIL b2b_0 got v=%b bin=%0d want v=1 bin=%0d", bus.out_valid, bus.out_bin, want[0]); else passes++;
        send(15'h003F);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== want[1]) $display("FAIL b2b_1 got v=%b bin=%0d want v=1 bin=%0d", bus.out_valid, bus.out_bin, want[1]); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== want[2] || bus.out_bubble !== 1'b0) $display("FAIL b2b_2 got v=%b bin=%0d bub=%b want v=1 bin=%0d bub=0", bus.out_valid, bus.out_bin, bus.out_bubble, want[2]); else passes++;
        drain();
    endtask

    task automatic test_stall();
        bus.out_ready = 1'b0;
        send(15'h0001);
        send(15'h0003);
        bus.in_valid = 1'b1;
        bus.in_therm = 15'h0007;
        repeat (3) begin
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b0) $display("FAIL stall_ready got %b want 0", bus.in_ready); else passes++;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd1 || bus.out_bubble !== 1'b0) $display("FAIL stall_hold got v=%b bin=%0d bub=%b want v=1 bin=1 bub=0", bus.out_valid, bus.out_bin, bus.out_bubble); else passes++;
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL stall_release got in_ready=%b want 1", bus.in_ready); else passes++;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd2) $display("FAIL stall_second got v=%b bin=%0d want v=1 bin=2", bus.out_valid, bus.out_bin); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd3) $display("FAIL stall_third got v=%b bin=%0d want v=1 bin=3", bus.out_valid, bus.out_bin); else passes++;
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL stall_empty got out_valid=%b want 0", bus.out_valid); else passes++;
        drain();
    endtask

    task automatic test_saturate();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 300; i++) send(15'b000000000000010);
        drain();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (err_count !== 8'd255) $display("FAIL sat_err got %0d want 255", err_count); else passes++;
        bus.out_ready = 1'b0;
        send(15'b000000000000100);
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bubble !== 1'b1) $display("FAIL clr_setup got v=%b bub=%b want v=1 bub=1", bus.out_valid, bus.out_bubble); else passes++;
        bus.out_ready = 1'b1;
        clr_err = 1'b1;
        @(posedge clk);
        #1 clr_err = 1'b0;
        checks++; if (err_count !== 8'd0) $display("FAIL clr_err got %0d want 0", err_count); else passes++;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL clr_xfer got out_valid=%b want 0", bus.out_valid); else passes++;
    endtask

    task automatic test_midflight_reset();
        bus.out_ready = 1'b1;
        send(15'b000000000000101);
        repeat (2) @(posedge clk);
        #1;
        checks++; if (err_count !== 8'd1) $display("FAIL mid_err_pre got %0d want 1", err_count); else passes++;
        bus.out_ready = 1'b0;
        send(15'h0001);
        send(15'h0003);
        checks++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL mid_full got v=%b rdy=%b want v=1 rdy=0", bus.out_valid, bus.in_ready); else passes++;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_rst_valid got %b want 0", bus.out_valid); else passes++;
        checks++; if (err_count !== 8'd0) $display("FAIL mid_rst_err got %0d want 0", err_count); else passes++;
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", bus.in_ready); else passes++;
        #1 rst = 1'b0;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            checks++; if (bus.out_valid !== 1'b0) $display("FAIL mid_stale got out_valid=%b want 0", bus.out_valid); else passes++;
        end
        send(15'h001F);
        @(posedge clk);
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_bin !== 4'd5) $display("FAIL mid_resume got v=%b bin=%0d want v=1 bin=5", bus.out_valid, bus.out_bin); else passes++;
        drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_therm = '0;
        bus.out_ready = 1'b1;
        fork
            monitor();
        join_none
        test_reset();
        test_basic();
        test_bubble();
        test_back_to_back();
        test_stall();
        test_saturate();
        test_midflight_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
